// File: rtl/sram_mem_controller_pkg.sv
// Shared types and constants for the SRAM memory controller: FSM state encoding,
// SRAM data width, phase-counter width and the byte-address to word-index mapping.
package sram_mem_controller_pkg;

    localparam int unsigned SRAM_DW = 16;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Word index relative to the SRAM base; the caller truncates to the SRAM word width.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr, input logic [31:0] base);
        return (byte_addr - base) >> 2;
    endfunction

endpackage

// File: rtl/sram_mem_controller_phase_counter.sv
// Loadable down-counter timing each half-word phase; load has priority and the count
// saturates at zero, which is flagged combinationally.
module sram_mem_controller_phase_counter
    import sram_mem_controller_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero_c
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_count  = r_count;
    assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/sram_mem_controller.sv
// MEM-stage controller splitting 32-bit loads/stores into two timed 16-bit SRAM
// phases (low half then high half) and freezing the pipeline while an access is in flight.
module sram_mem_controller
    import sram_mem_controller_pkg::*;
#(
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned BASE_ADDR   = 1024
)
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_rd_en,
    input  logic               i_wr_en,
    input  logic [31:0]        i_address,
    input  logic [31:0]        i_write_data,
    output logic [31:0]        o_read_data,
    output logic               o_ready,
    output logic               o_freeze,
    output logic [ADDR_W-1:0]  o_sram_addr,
    output logic [SRAM_DW-1:0] o_sram_dq_out,
    output logic               o_sram_dq_oe,
    input  logic [SRAM_DW-1:0] i_sram_dq_in,
    output logic               o_sram_we_n
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(WAIT_CYCLES - 1);
    // With a single cycle per phase that cycle is also the last, so no strobe is issued.
    localparam bit MULTI_CYCLE = (WAIT_CYCLES > 32'd1);

    state_t              r_state;
    logic                r_is_wr;
    logic [ADDR_W-2:0]   r_word;
    logic [31:0]         r_wdata;
    logic [SRAM_DW-1:0]  r_lo_buf;
    logic [31:0]         r_read_data;
    logic                r_ready;
    logic [ADDR_W-1:0]   r_sram_addr;
    logic [SRAM_DW-1:0]  r_dq_out;
    logic                r_dq_oe;
    logic                r_we_n;

    logic                w_req;
    logic [ADDR_W-2:0]   w_word;
    logic                w_load;
    logic                w_dec;
    logic [CNT_W-1:0]    w_count;
    logic                w_zero;

    assign w_req  = i_rd_en || i_wr_en;
    assign w_word = (ADDR_W-1)'(word_index(i_address, 32'(BASE_ADDR)));
    assign w_load = ((r_state == ST_IDLE) && w_req) || ((r_state == ST_LOW) && w_zero);
    assign w_dec  = ((r_state == ST_LOW) || (r_state == ST_HIGH)) && !w_zero;

    sram_mem_controller_phase_counter u_phase_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_load_val (RELOAD),
        .i_dec      (w_dec),
        .o_count    (w_count),
        .o_zero_c   (w_zero)
    );

    // Sequencer; every SRAM-facing output is set up for the cycle the FSM enters next.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= ST_IDLE;
            r_is_wr     <= 1'b0;
            r_word      <= '0;
            r_wdata     <= '0;
            r_lo_buf    <= '0;
            r_read_data <= '0;
            r_ready     <= 1'b0;
            r_sram_addr <= '0;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_state     <= ST_LOW;
                        r_is_wr     <= i_wr_en;
                        r_word      <= w_word;
                        r_wdata     <= i_write_data;
                        r_sram_addr <= {w_word, 1'b0};
                        r_dq_out    <= i_write_data[15:0];
                        r_dq_oe     <= i_wr_en;
                        r_we_n      <= !(i_wr_en && MULTI_CYCLE);
                    end
                end
                ST_LOW: begin
                    if (w_zero) begin
                        r_state     <= ST_HIGH;
                        r_sram_addr <= {r_word, 1'b1};
                        r_dq_out    <= r_wdata[31:16];
                        r_we_n      <= !(r_is_wr && MULTI_CYCLE);
                        if (!r_is_wr) begin
                            r_lo_buf <= i_sram_dq_in;
                        end
                    end else begin
                        r_we_n <= !(r_is_wr && (w_count != CNT_W'(1)));
                    end
                end
                ST_HIGH: begin
                    if (w_zero) begin
                        r_state <= ST_DONE;
                        r_ready <= 1'b1;
                        r_dq_oe <= 1'b0;
                        r_we_n  <= 1'b1;
                        // Low half is staged so read_data changes only when a load completes.
                        if (!r_is_wr) begin
                            r_read_data <= {i_sram_dq_in, r_lo_buf};
                        end
                    end else begin
                        r_we_n <= !(r_is_wr && (w_count != CNT_W'(1)));
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_read_data   = r_read_data;
    assign o_ready       = r_ready;
    assign o_freeze      = w_req && !r_ready;
    assign o_sram_addr   = r_sram_addr;
    assign o_sram_dq_out = r_dq_out;
    assign o_sram_dq_oe  = r_dq_oe;
    assign o_sram_we_n   = r_we_n;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench: instance A (2 wait cycles) against a small SRAM array model,
// instance B (1 wait cycle) against an address-derived read pattern.
module tb_sram_mem_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        rd_a, wr_a, ready_a, freeze_a, oe_a, we_n_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic [17:0] saddr_a;
    logic [15:0] dq_out_a, dq_in_a;

    logic        rd_b, wr_b, ready_b, freeze_b, oe_b, we_n_b;
    logic [31:0] addr_b, wdata_b, rdata_b;
    logic [17:0] saddr_b;
    logic [15:0] dq_out_b, dq_in_b;

    logic [15:0] mem [0:63];

    int n_cmp = 0;
    int n_bad = 0;

    sram_mem_controller u_dut_a (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_rd_en       (rd_a),
        .i_wr_en       (wr_a),
        .i_address     (addr_a),
        .i_write_data  (wdata_a),
        .o_read_data   (rdata_a),
        .o_ready       (ready_a),
        .o_freeze      (freeze_a),
        .o_sram_addr   (saddr_a),
        .o_sram_dq_out (dq_out_a),
        .o_sram_dq_oe  (oe_a),
        .i_sram_dq_in  (dq_in_a),
        .o_sram_we_n   (we_n_a)
    );

    sram_mem_controller #(.WAIT_CYCLES(1)) u_dut_b (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_rd_en       (rd_b),
        .i_wr_en       (wr_b),
        .i_address     (addr_b),
        .i_write_data  (wdata_b),
        .o_read_data   (rdata_b),
        .o_ready       (ready_b),
        .o_freeze      (freeze_b),
        .o_sram_addr   (saddr_b),
        .o_sram_dq_out (dq_out_b),
        .o_sram_dq_oe  (oe_b),
        .i_sram_dq_in  (dq_in_b),
        .o_sram_we_n   (we_n_b)
    );

    always @(posedge clk) begin
        if (!we_n_a) mem[saddr_a[5:0]] <= dq_out_a;
    end
    assign dq_in_a = mem[saddr_a[5:0]];
    assign dq_in_b = 16'hA000 | {4'h0, saddr_b[11:0]};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Full access on A: starts in the current cycle T, ends sampling the ready cycle T+5.
    task automatic access_a(input logic wr, input logic rd, input logic [31:0] addr,
                            input logic [31:0] data, input logic [17:0] half0,
                            input logic [31:0] exp_rd);
        wr_a = wr; rd_a = rd; addr_a = addr; wdata_a = data;
        #1 check_eq("freeze_T", freeze_a, 1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check_eq($sformatf("ready_c%0d", k), ready_a, 32'(k == 5));
            check_eq($sformatf("freeze_c%0d", k), freeze_a, 32'(k < 5));
            if (k < 5) begin
                check_eq($sformatf("saddr_c%0d", k), saddr_a, half0 + 18'(k > 2));
                check_eq($sformatf("oe_c%0d", k), oe_a, wr);
                check_eq($sformatf("we_n_c%0d", k), we_n_a, !(wr && (k == 1 || k == 3)));
                if (wr) check_eq($sformatf("dq_c%0d", k), dq_out_a, (k <= 2) ? data[15:0] : data[31:16]);
            end else begin
                check_eq("oe_done", oe_a, 0);
                check_eq("we_n_done", we_n_a, 1);
                check_eq("read_data", rdata_a, exp_rd);
            end
        end
    endtask

    task automatic go_idle_a();
        wr_a = 1'b0; rd_a = 1'b0;
        #1 check_eq("idle_freeze", freeze_a, 0);
        @(negedge clk);
        check_eq("idle_oe", oe_a, 0);
        check_eq("idle_we_n", we_n_a, 1);
        check_eq("idle_ready", ready_a, 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        rst = 1'b0;
        rd_a = 1'b0; wr_a = 1'b0; addr_a = '0; wdata_a = '0;
        rd_b = 1'b0; wr_b = 1'b0; addr_b = '0; wdata_b = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", ready_a, 0);
        check_eq("rst_rdata", rdata_a, 0);
        check_eq("rst_saddr", saddr_a, 0);
        check_eq("rst_dq_out", dq_out_a, 0);
        check_eq("rst_oe", oe_a, 0);
        check_eq("rst_we_n", we_n_a, 1);
        check_eq("rst_freeze", freeze_a, 0);
        check_eq("rst_b_ready", ready_b, 0);
        rst = 1'b1;
        @(negedge clk);

        access_a(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 18'd2, 32'h0);
        @(negedge clk); go_idle_a();
        access_a(1'b0, 1'b1, 32'd1028, 32'h0, 18'd2, 32'hDEADBEEF);
        @(negedge clk); go_idle_a();

        // Store then load with no gap cycle after DONE.
        access_a(1'b1, 1'b0, 32'd1024, 32'hCAFEF00D, 18'd0, 32'hDEADBEEF);
        @(negedge clk);
        access_a(1'b0, 1'b1, 32'd1024, 32'h0, 18'd0, 32'hCAFEF00D);
        @(negedge clk); go_idle_a();

        // Both enables: store wins, read_data untouched.
        access_a(1'b1, 1'b1, 32'd1032, 32'h12345678, 18'd4, 32'hCAFEF00D);
        @(negedge clk); go_idle_a();
        access_a(1'b0, 1'b1, 32'd1032, 32'h0, 18'd4, 32'h12345678);
        @(negedge clk); go_idle_a();

        // Reset in the middle of the first LOW cycle of a store.
        wr_a = 1'b1; addr_a = 32'd1036; wdata_a = 32'h5555AAAA;
        @(negedge clk);
        check_eq("pre_rst_we_n", we_n_a, 0);
        check_eq("pre_rst_oe", oe_a, 1);
        rst = 1'b0; wr_a = 1'b0;
        #1;
        check_eq("async_we_n", we_n_a, 1);
        check_eq("async_oe", oe_a, 0);
        check_eq("async_ready", ready_a, 0);
        check_eq("async_saddr", saddr_a, 0);
        check_eq("async_rdata", rdata_a, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("post_rst_freeze", freeze_a, 0);
        check_eq("post_rst_oe", oe_a, 0);
        check_eq("post_rst_we_n", we_n_a, 1);
        // Aborted store must not have reached the array; a fresh load runs from IDLE.
        access_a(1'b0, 1'b1, 32'd1036, 32'h0, 18'd6, 32'h0);
        @(negedge clk); go_idle_a();

        // Instance B, one wait cycle per phase: ready at T+3.
        rd_b = 1'b1; addr_b = 32'd1036;
        #1 check_eq("b_freeze_T", freeze_b, 1);
        @(negedge clk);
        check_eq("b_saddr_c1", saddr_b, 18'd6);
        check_eq("b_oe_c1", oe_b, 0);
        check_eq("b_we_n_c1", we_n_b, 1);
        check_eq("b_ready_c1", ready_b, 0);
        @(negedge clk);
        check_eq("b_saddr_c2", saddr_b, 18'd7);
        check_eq("b_ready_c2", ready_b, 0);
        check_eq("b_freeze_c2", freeze_b, 1);
        @(negedge clk);
        check_eq("b_ready_c3", ready_b, 1);
        check_eq("b_freeze_c3", freeze_b, 0);
        check_eq("b_rdata_1", rdata_b, 32'hA007A006);

        // Request withdrawn one cycle after acceptance: access still completes.
        @(negedge clk);
        addr_b = 32'd1040;
        #1 check_eq("b2_freeze_T", freeze_b, 1);
        @(negedge clk);
        check_eq("b2_saddr_c1", saddr_b, 18'd8);
        rd_b = 1'b0;
        #1 check_eq("b2_freeze_drop", freeze_b, 0);
        @(negedge clk);
        check_eq("b2_saddr_c2", saddr_b, 18'd9);
        check_eq("b2_ready_c2", ready_b, 0);
        @(negedge clk);
        check_eq("b2_ready_c3", ready_b, 1);
        check_eq("b2_freeze_c3", freeze_b, 0);
        check_eq("b2_rdata", rdata_b, 32'hA009A008);
        @(negedge clk);
        check_eq("b2_ready_after", ready_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
